// File: rtl/rv_pipe_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rv_pipe_pkg : shared pipeline-control encodings for the RV32I core
// Rev 1.0
// ---------------------------------------------------------------------------
package rv_pipe_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [4:0] REG_X0  = 5'd0;

   typedef enum logic {
      ST_BOOT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // The younger producer in M takes priority over W.
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] rs,
      input logic [4:0] rd_m,
      input logic       wr_m,
      input logic [4:0] rd_w,
      input logic       wr_w
   );
      if (wr_m && (rd_m != REG_X0) && (rd_m == rs))
         return FWD_MEM;
      else if (wr_w && (rd_w != REG_X0) && (rd_w == rs))
         return FWD_WB;
      else
         return FWD_RF;
   endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_sat_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sat_counter : W-bit up counter that sticks at all-ones
// Rev 1.0
// ---------------------------------------------------------------------------
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] q
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else if (en && (cnt_q != {W{1'b1}}))
         cnt_q <= cnt_q + 1'b1;
   end

   assign q = cnt_q;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_ctrl : stall/flush/forwarding control with boot hold and perf counters
// Rev 1.0
// ---------------------------------------------------------------------------
module hazard_ctrl
   import rv_pipe_pkg::*;
#(
   parameter int BOOT_CYCLES = 4,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       rs1D,
   input  logic [4:0]       rs2D,
   input  logic [4:0]       rs1E,
   input  logic [4:0]       rs2E,
   input  logic [4:0]       rdE,
   input  logic             memReadE,
   input  logic [4:0]       rdM,
   input  logic             regWriteM,
   input  logic [4:0]       rdW,
   input  logic             regWriteW,
   input  logic             PCsrcM,
   output logic             stallF,
   output logic             stallD,
   output logic             flushD,
   output logic             flushE,
   output logic [1:0]       forwardAE,
   output logic [1:0]       forwardBE,
   output logic             booting,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int            BW        = (BOOT_CYCLES < 1) ? 1 : $clog2(BOOT_CYCLES + 1);
   localparam logic [BW-1:0] BOOT_LAST = (BOOT_CYCLES < 1) ? '0 : BW'(BOOT_CYCLES - 1);

   state_e        state_q;
   logic [BW-1:0] boot_q;
   logic          w_run;
   logic          w_load_use;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_BOOT;
         boot_q  <= '0;
      end else if (state_q == ST_BOOT) begin
         if ((BOOT_CYCLES < 1) || (boot_q == BOOT_LAST))
            state_q <= ST_RUN;
         else
            boot_q <= boot_q + 1'b1;
      end
   end

   // Reset overrides RUN immediately so the pipe is held while rst is high.
   assign w_run      = (state_q == ST_RUN) && !rst;
   assign w_load_use = memReadE && (rdE != REG_X0) && ((rdE == rs1D) || (rdE == rs2D));

   always_comb begin
      {stallF, stallD, flushD, flushE} = 4'b1111;
      if (w_run) begin
         if (PCsrcM)
            {stallF, stallD, flushD, flushE} = 4'b0011;
         else if (w_load_use)
            {stallF, stallD, flushD, flushE} = 4'b1101;
         else
            {stallF, stallD, flushD, flushE} = 4'b0000;
      end
   end

   assign forwardAE = w_run ? fwd_sel(rs1E, rdM, regWriteM, rdW, regWriteW) : FWD_RF;
   assign forwardBE = w_run ? fwd_sel(rs2E, rdM, regWriteM, rdW, regWriteW) : FWD_RF;
   assign booting   = !w_run;

   sat_counter #(.W(CNT_W)) u_cycle_cnt (
      .clk (clk),
      .rst (rst),
      .en  (w_run),
      .q   (cycle_cnt)
   );

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .en  (w_run && stallF),
      .q   (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk (clk),
      .rst (rst),
      .en  (w_run && PCsrcM),
      .q   (flush_cnt)
   );

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_hazard_ctrl : directed self-checking bench for hazard_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
   logic       memReadE, regWriteM, regWriteW, PCsrcM;
   logic       stallF, stallD, flushD, flushE, booting;
   logic [1:0] forwardAE, forwardBE;
   logic [3:0] cycle_cnt, stall_cnt, flush_cnt;

   int n_cmp = 0;
   int n_err = 0;

   hazard_ctrl #(.BOOT_CYCLES(4), .CNT_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .rs1D      (rs1D),
      .rs2D      (rs2D),
      .rs1E      (rs1E),
      .rs2E      (rs2E),
      .rdE       (rdE),
      .memReadE  (memReadE),
      .rdM       (rdM),
      .regWriteM (regWriteM),
      .rdW       (rdW),
      .regWriteW (regWriteW),
      .PCsrcM    (PCsrcM),
      .stallF    (stallF),
      .stallD    (stallD),
      .flushD    (flushD),
      .flushE    (flushE),
      .forwardAE (forwardAE),
      .forwardBE (forwardBE),
      .booting   (booting),
      .cycle_cnt (cycle_cnt),
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
   );

   always #5 clk = ~clk;

   // {stallF, stallD, flushD, flushE, booting}
   logic [4:0] ctl;
   assign ctl = {stallF, stallD, flushD, flushE, booting};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW} = '0;
      {memReadE, regWriteM, regWriteW, PCsrcM} = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW} = 'x;
      {memReadE, regWriteM, regWriteW, PCsrcM} = 'x;
      repeat (3) tick();
      n_cmp++;
      if (ctl !== 5'b11111) begin
         n_err++; $display("FAIL reset_ctl: got %b want 11111", ctl);
      end
      n_cmp++;
      if ({forwardAE, forwardBE} !== 4'b0000) begin
         n_err++; $display("FAIL reset_fwd: got %b want 0000", {forwardAE, forwardBE});
      end
      n_cmp++;
      if ({cycle_cnt, stall_cnt, flush_cnt} !== 12'h000) begin
         n_err++; $display("FAIL reset_cnt: got %h want 000", {cycle_cnt, stall_cnt, flush_cnt});
      end
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_cmp++;
         if ({ctl, forwardAE, cycle_cnt} !== {5'b11111, 2'b00, 4'd0}) begin
            n_err++; $display("FAIL boot_hold[%0d]: got %b want 11111_00_0000", i, {ctl, forwardAE, cycle_cnt});
         end
         tick();
      end
      clear_inputs();
      #1;
      n_cmp++;
      if ({ctl, cycle_cnt} !== {5'b00000, 4'd0}) begin
         n_err++; $display("FAIL boot_done: got %b want 00000_0000", {ctl, cycle_cnt});
      end
      tick();
      n_cmp++;
      if (cycle_cnt !== 4'd1) begin
         n_err++; $display("FAIL cycle_cnt_first: got %0d want 1", cycle_cnt);
      end
   endtask

   task automatic test_load_use();
      memReadE = 1'b1; rdE = 5'd5; rs1D = 5'd5; rs2D = 5'd6;
      #1;
      n_cmp++;
      if (ctl !== 5'b11010) begin
         n_err++; $display("FAIL load_use_rs1: got %b want 11010", ctl);
      end
      tick();
      clear_inputs();
      #1;
      n_cmp++;
      if ({ctl, stall_cnt} !== {5'b00000, 4'd1}) begin
         n_err++; $display("FAIL load_use_one_bubble: got %b want 00000_0001", {ctl, stall_cnt});
      end
      memReadE = 1'b1; rdE = 5'd9; rs1D = 5'd1; rs2D = 5'd9;
      #1;
      n_cmp++;
      if (ctl !== 5'b11010) begin
         n_err++; $display("FAIL load_use_rs2: got %b want 11010", ctl);
      end
      tick();
      clear_inputs();
      #1;
      n_cmp++;
      if (stall_cnt !== 4'd2) begin
         n_err++; $display("FAIL stall_cnt_two: got %0d want 2", stall_cnt);
      end
   endtask

   task automatic test_x0_load();
      memReadE = 1'b1; rdE = 5'd0; rs1D = 5'd0; rs2D = 5'd0;
      #1;
      n_cmp++;
      if (ctl !== 5'b00000) begin
         n_err++; $display("FAIL x0_load: got %b want 00000", ctl);
      end
      memReadE = 1'b0; rdE = 5'd4; rs1D = 5'd4;
      #1;
      n_cmp++;
      if (ctl !== 5'b00000) begin
         n_err++; $display("FAIL not_a_load: got %b want 00000", ctl);
      end
      tick();
      clear_inputs();
      n_cmp++;
      if (stall_cnt !== 4'd2) begin
         n_err++; $display("FAIL x0_no_count: got %0d want 2", stall_cnt);
      end
   endtask

   task automatic test_redirect();
      PCsrcM = 1'b1; memReadE = 1'b1; rdE = 5'd7; rs2D = 5'd7;
      #1;
      n_cmp++;
      if (ctl !== 5'b00110) begin
         n_err++; $display("FAIL redirect_over_load_use: got %b want 00110", ctl);
      end
      tick();
      clear_inputs();
      #1;
      n_cmp++;
      if ({flush_cnt, stall_cnt} !== {4'd1, 4'd2}) begin
         n_err++; $display("FAIL redirect_counts: got %h want 12", {flush_cnt, stall_cnt});
      end
      PCsrcM = 1'b1;
      #1;
      n_cmp++;
      if (ctl !== 5'b00110) begin
         n_err++; $display("FAIL redirect_alone: got %b want 00110", ctl);
      end
      tick();
      clear_inputs();
      n_cmp++;
      if (flush_cnt !== 4'd2) begin
         n_err++; $display("FAIL flush_cnt_two: got %0d want 2", flush_cnt);
      end
   endtask

   task automatic test_forwarding();
      rs1E = 5'd3; rdM = 5'd3; regWriteM = 1'b1; rdW = 5'd3; regWriteW = 1'b1;
      #1;
      n_cmp++;
      if ({forwardAE, forwardBE} !== 4'b1000) begin
         n_err++; $display("FAIL fwd_mem_beats_wb: got %b want 1000", {forwardAE, forwardBE});
      end
      regWriteM = 1'b0;
      #1;
      n_cmp++;
      if (forwardAE !== 2'b01) begin
         n_err++; $display("FAIL fwd_wb: got %b want 01", forwardAE);
      end
      regWriteM = 1'b1; rdM = 5'd0; rdW = 5'd0;
      #1;
      n_cmp++;
      if (forwardAE !== 2'b00) begin
         n_err++; $display("FAIL fwd_none: got %b want 00", forwardAE);
      end
      rs1E = 5'd0; rs2E = 5'd0;
      #1;
      n_cmp++;
      if ({forwardAE, forwardBE} !== 4'b0000) begin
         n_err++; $display("FAIL fwd_x0: got %b want 0000", {forwardAE, forwardBE});
      end
      rs1E = 5'd8; rs2E = 5'd4; rdM = 5'd8; regWriteM = 1'b1; rdW = 5'd4; regWriteW = 1'b1;
      #1;
      n_cmp++;
      if ({forwardAE, forwardBE} !== 4'b1001) begin
         n_err++; $display("FAIL fwd_split: got %b want 1001", {forwardAE, forwardBE});
      end
      clear_inputs();
   endtask

   task automatic test_saturation();
      memReadE = 1'b1; rdE = 5'd12; rs1D = 5'd12;
      repeat (20) tick();
      n_cmp++;
      if ({stallF, stall_cnt} !== {1'b1, 4'd15}) begin
         n_err++; $display("FAIL stall_cnt_sat: got %b want 1_1111", {stallF, stall_cnt});
      end
      n_cmp++;
      if ({cycle_cnt, flush_cnt} !== {4'd15, 4'd2}) begin
         n_err++; $display("FAIL cycle_cnt_sat: got %h want f2", {cycle_cnt, flush_cnt});
      end
   endtask

   task automatic test_rst_midrun();
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({ctl, forwardAE} !== {5'b11111, 2'b00}) begin
         n_err++; $display("FAIL rst_in_run: got %b want 11111_00", {ctl, forwardAE});
      end
      tick();
      rst = 1'b0;
      n_cmp++;
      if ({cycle_cnt, stall_cnt, flush_cnt, booting} !== {12'h000, 1'b1}) begin
         n_err++; $display("FAIL rst_midrun_clear: got %h_%b want 000_1", {cycle_cnt, stall_cnt, flush_cnt}, booting);
      end
      repeat (3) tick();
      n_cmp++;
      if ({ctl, stall_cnt} !== {5'b11111, 4'd0}) begin
         n_err++; $display("FAIL reboot_hold: got %b want 11111_0000", {ctl, stall_cnt});
      end
      tick();
      n_cmp++;
      if (ctl !== 5'b11010) begin
         n_err++; $display("FAIL reboot_run: got %b want 11010", ctl);
      end
      tick();
      n_cmp++;
      if ({cycle_cnt, stall_cnt} !== {4'd1, 4'd1}) begin
         n_err++; $display("FAIL reboot_counts: got %h want 11", {cycle_cnt, stall_cnt});
      end
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_load_use();
      test_x0_load();
      test_redirect();
      test_forwarding();
      test_saturation();
      test_rst_midrun();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
